// File: rtl/reuleaux_pkg.sv
// Shared types and constants for the Reuleaux triangle renderer.
package reuleaux_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ARC1,
    S_ARC2,
    S_ARC3,
    S_DONE
  } state_t;

  // Which arc centre is loaded into the circle engine.
  typedef enum logic [1:0] {
    SEL_C1,
    SEL_C2,
    SEL_C3
  } csel_t;

  // sqrt(3)/6 and sqrt(3)/3 as fixed-point fractions of 2^SQRT_SHIFT.
  localparam int unsigned SQRT3_6_NUM = 148;
  localparam int unsigned SQRT3_3_NUM = 296;
  localparam int unsigned SQRT_SHIFT  = 9;

  localparam int SCR_W_DEFAULT = 160;
  localparam int SCR_H_DEFAULT = 120;

  // Arc centres fit in 10 bits signed.
  typedef logic signed [9:0] coord_t;
  // Candidate points reach centre +/- radius, which can exceed 10 bits.
  typedef logic signed [11:0] cand_t;

  function automatic cand_t widen(input coord_t c);
    return {{2{c[9]}}, c};
  endfunction

endpackage

// File: rtl/reuleaux_octant_stepper.sv
// Midpoint-circle engine: emits one octant point per step, eight per iteration.
module octant_stepper
  import reuleaux_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  coord_t     cx,
  input  coord_t     cy,
  input  logic [7:0] r,
  input  logic       step,
  output cand_t      px,
  output cand_t      py,
  output logic       last
);

  cand_t      r_cx;
  cand_t      r_cy;
  cand_t      r_ox;
  cand_t      r_oy;
  cand_t      r_crit;
  logic [2:0] r_oct;

  cand_t w_oy_n;
  cand_t w_ox_n;
  cand_t w_crit_n;
  logic  w_end;

  // Offsets and decision term for the iteration after the current one.
  always_comb begin
    w_oy_n = r_oy + 12'sd1;
    if (r_crit[11] || (r_crit == '0)) begin
      w_ox_n   = r_ox;
      w_crit_n = r_crit + (w_oy_n <<< 1) + 12'sd1;
    end else begin
      w_ox_n   = r_ox - 12'sd1;
      w_crit_n = r_crit + ((w_oy_n - w_ox_n) <<< 1) + 12'sd1;
    end
    w_end = (w_oy_n > w_ox_n);
  end

  assign last = (r_oct == 3'd7) && w_end;

  // Octant point for the current phase, octants 1..8 in order.
  always_comb begin
    px = r_cx;
    py = r_cy;
    case (r_oct)
      3'd0: begin px = r_cx + r_ox; py = r_cy + r_oy; end
      3'd1: begin px = r_cx + r_oy; py = r_cy + r_ox; end
      3'd2: begin px = r_cx - r_ox; py = r_cy + r_oy; end
      3'd3: begin px = r_cx - r_oy; py = r_cy + r_ox; end
      3'd4: begin px = r_cx - r_ox; py = r_cy - r_oy; end
      3'd5: begin px = r_cx - r_oy; py = r_cy - r_ox; end
      3'd6: begin px = r_cx + r_ox; py = r_cy - r_oy; end
      default: begin px = r_cx + r_oy; py = r_cy - r_ox; end
    endcase
  end

  // Load a new centre/radius or advance one octant phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cx   <= '0;
      r_cy   <= '0;
      r_ox   <= '0;
      r_oy   <= '0;
      r_crit <= '0;
      r_oct  <= '0;
    end else if (load) begin
      r_cx   <= widen(cx);
      r_cy   <= widen(cy);
      r_ox   <= {4'd0, r};
      r_oy   <= '0;
      r_crit <= 12'sd1 - {4'd0, r};
      r_oct  <= '0;
    end else if (step) begin
      if (r_oct == 3'd7) begin
        r_oct  <= '0;
        r_oy   <= w_oy_n;
        r_ox   <= w_ox_n;
        r_crit <= w_crit_n;
      end else begin
        r_oct <= r_oct + 3'd1;
      end
    end
  end

endmodule

// File: rtl/reuleaux.sv
// Reuleaux triangle outline renderer: three windowed midpoint arcs, one candidate per clock.
module reuleaux
  import reuleaux_pkg::*;
#(
  parameter int SCR_W = SCR_W_DEFAULT,
  parameter int SCR_H = SCR_H_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam cand_t W_LIM = cand_t'(SCR_W);
  localparam cand_t H_LIM = cand_t'(SCR_H);

  state_t     r_state;
  state_t     w_state_nx;
  logic       r_tail;

  logic [7:0] r_cx;
  logic [6:0] r_cy;
  logic [7:0] r_d;
  logic [2:0] r_colour;

  coord_t     r_c1x, r_c1y, r_c2x, r_c3x, r_c3y;
  coord_t     w_c1x, w_c1y, w_c2x, w_c3x, w_c3y;
  logic [16:0] w_p6, w_p3;
  logic [7:0] w_h6, w_h3;
  logic [9:0] w_half;

  logic       w_accept;
  logic       w_load;
  logic       w_step;
  logic       w_cand;
  logic       w_last;
  logic       w_win;
  logic       w_screen;
  csel_t      w_sel;
  coord_t     w_ld_cx, w_ld_cy;
  cand_t      w_px, w_py;
  cand_t      w_e1x, w_e1y, w_e2x, w_e3x, w_e3y;

  logic [7:0] r_x;
  logic [6:0] r_y;
  logic       r_plot;
  logic       r_done;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Triangle geometry from the latched request.
  assign w_p6   = {9'd0, r_d} * 17'(SQRT3_6_NUM);
  assign w_p3   = {9'd0, r_d} * 17'(SQRT3_3_NUM);
  assign w_h6   = 8'(w_p6 >> SQRT_SHIFT);
  assign w_h3   = 8'(w_p3 >> SQRT_SHIFT);
  assign w_half = {3'd0, r_d[7:1]};
  assign w_c1x  = {2'd0, r_cx} + w_half;
  assign w_c2x  = {2'd0, r_cx} - w_half;
  assign w_c3x  = {2'd0, r_cx};
  assign w_c1y  = {3'd0, r_cy} + {2'd0, w_h6};
  assign w_c3y  = {3'd0, r_cy} - {2'd0, w_h3};

  // Centre fed to the engine when it is reloaded.
  always_comb begin
    w_ld_cx = w_c1x;
    w_ld_cy = w_c1y;
    case (w_sel)
      SEL_C2:  begin w_ld_cx = w_c2x; w_ld_cy = w_c1y; end
      SEL_C3:  begin w_ld_cx = w_c3x; w_ld_cy = w_c3y; end
      default: begin w_ld_cx = w_c1x; w_ld_cy = w_c1y; end
    endcase
  end

  octant_stepper u_stepper (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .cx    (w_ld_cx),
    .cy    (w_ld_cy),
    .r     (r_d),
    .step  (w_step),
    .px    (w_px),
    .py    (w_py),
    .last  (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next state and engine control; each arc ends with one idle tail cycle
  // so its final strobe drains before the next arc or DONE.
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_sel      = SEL_C1;
    w_cand     = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_SETUP;
      S_SETUP: begin
        w_state_nx = S_ARC1;
        w_load     = 1'b1;
        w_sel      = SEL_C1;
      end
      S_ARC1: begin
        if (r_tail) begin
          w_state_nx = S_ARC2;
          w_load     = 1'b1;
          w_sel      = SEL_C2;
        end else begin
          w_step = 1'b1;
          w_cand = 1'b1;
        end
      end
      S_ARC2: begin
        if (r_tail) begin
          w_state_nx = S_ARC3;
          w_load     = 1'b1;
          w_sel      = SEL_C3;
        end else begin
          w_step = 1'b1;
          w_cand = 1'b1;
        end
      end
      S_ARC3: begin
        if (r_tail) begin
          w_state_nx = S_DONE;
        end else begin
          w_step = 1'b1;
          w_cand = 1'b1;
        end
      end
      S_DONE:  if (start) w_state_nx = S_SETUP;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Marks the cycle after an arc's final candidate.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_tail <= 1'b0;
    else if (w_cand) r_tail <= w_last;
    else             r_tail <= 1'b0;
  end

  // Latch the request on an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_d      <= '0;
      r_colour <= '0;
    end else if (w_accept) begin
      r_cx     <= centre_x;
      r_cy     <= centre_y;
      r_d      <= diameter;
      r_colour <= colour;
    end
  end

  // Capture the arc centres used by the plot windows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c1x <= '0;
      r_c1y <= '0;
      r_c2x <= '0;
      r_c3x <= '0;
      r_c3y <= '0;
    end else if (r_state == S_SETUP) begin
      r_c1x <= w_c1x;
      r_c1y <= w_c1y;
      r_c2x <= w_c2x;
      r_c3x <= w_c3x;
      r_c3y <= w_c3y;
    end
  end

  assign w_e1x = widen(r_c1x);
  assign w_e1y = widen(r_c1y);
  assign w_e2x = widen(r_c2x);
  assign w_e3x = widen(r_c3x);
  assign w_e3y = widen(r_c3y);

  // Arc window and screen clip for the current candidate.
  always_comb begin
    w_win = 1'b0;
    case (r_state)
      S_ARC1:  w_win = (w_px >= w_e2x) && (w_px <= w_e3x) && (w_py >= w_e3y) && (w_py <= w_e1y);
      S_ARC2:  w_win = (w_px >= w_e3x) && (w_px <= w_e1x) && (w_py >= w_e3y) && (w_py <= w_e1y);
      S_ARC3:  w_win = (w_px >= w_e2x) && (w_px <= w_e1x) && (w_py >= w_e1y);
      default: w_win = 1'b0;
    endcase
    w_screen = !w_px[11] && (w_px < W_LIM) && !w_py[11] && (w_py < H_LIM);
  end

  // Registered pixel strobe and completion flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_plot <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_plot <= w_cand && w_win && w_screen;
      if (w_cand) begin
        r_x <= w_px[7:0];
        r_y <= w_py[6:0];
      end
      r_done <= (w_state_nx == S_DONE);
    end
  end

  assign done       = r_done;
  assign vga_x      = r_x;
  assign vga_y      = r_y;
  assign vga_colour = r_colour;
  assign vga_plot   = r_plot;

endmodule

// File: tb/tb_reuleaux.sv
// Scoreboard bench for reuleaux: a behavioural model queues expected strobes,
// a monitor pops and compares on every vga_plot.
module tb_reuleaux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] colour = '0;
  logic [7:0] centre_x = '0;
  logic [6:0] centre_y = '0;
  logic [7:0] diameter = '0;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  always #5 clk = ~clk;

  reuleaux #(.SCR_W(160), .SCR_H(120)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .colour     (colour),
    .centre_x   (centre_x),
    .centre_y   (centre_y),
    .diameter   (diameter),
    .start      (start),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   rises  = 0;
  logic prev_done = 1'b0;
  bit   fb [160][120];

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic bit in_window(input int a, input int x, input int y,
                                   input int c1x, input int c1y, input int c2x,
                                   input int c3x, input int c3y);
    case (a)
      0:       return (x >= c2x) && (x <= c3x) && (y >= c3y) && (y <= c1y);
      1:       return (x >= c3x) && (x <= c1x) && (y >= c3y) && (y <= c1y);
      default: return (x >= c2x) && (x <= c1x) && (y >= c1y);
    endcase
  endfunction

  // Golden model: queue every strobe the shape should produce, in order.
  task automatic push_shape(input int cx, input int cy, input int d, input logic [2:0] col);
    int h6, h3, c1x, c1y, c2x, c3x, c3y, ccx, ccy, ox, oy, crit;
    int px [8];
    int py [8];
    pix_t p;
    h6  = (d * 148) >> 9;
    h3  = (d * 296) >> 9;
    c1x = cx + d / 2;
    c2x = cx - d / 2;
    c3x = cx;
    c1y = cy + h6;
    c3y = cy - h3;
    for (int a = 0; a < 3; a++) begin
      ccx  = (a == 0) ? c1x : (a == 1) ? c2x : c3x;
      ccy  = (a == 2) ? c3y : c1y;
      ox   = d;
      oy   = 0;
      crit = 1 - d;
      while (oy <= ox) begin
        px = '{ccx + ox, ccx + oy, ccx - ox, ccx - oy, ccx - ox, ccx - oy, ccx + ox, ccx + oy};
        py = '{ccy + oy, ccy + ox, ccy + oy, ccy + ox, ccy - oy, ccy - ox, ccy - oy, ccy - ox};
        for (int k = 0; k < 8; k++) begin
          if (in_window(a, px[k], py[k], c1x, c1y, c2x, c3x, c3y) &&
              px[k] >= 0 && px[k] < 160 && py[k] >= 0 && py[k] < 120) begin
            p.x = px[k][7:0];
            p.y = py[k][6:0];
            p.c = col;
            exp_q.push_back(p);
          end
        end
        oy++;
        if (crit <= 0) crit += 2 * oy + 1;
        else begin
          ox--;
          crit += 2 * (oy - ox) + 1;
        end
      end
    end
  endtask

  // Monitor: compare each strobe against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done && !prev_done) rises++;
      prev_done = done;
      if (vga_plot) begin
        checks++;
        if (!(vga_x < 160 && vga_y < 120)) begin
          errors++;
          $display("FAIL onscreen: got (%0d,%0d) want x<160 y<120", vga_x, vga_y);
        end else begin
          fb[vga_x][vga_y] = 1'b1;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_plot: got (%0d,%0d,c%0d) want no strobe", vga_x, vga_y, vga_colour);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.x !== vga_x || mon_e.y !== vga_y || mon_e.c !== vga_colour) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                     vga_x, vga_y, vga_colour, mon_e.x, mon_e.y, mon_e.c);
          end
        end
      end
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic clear_fb();
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++)
        fb[i][j] = 1'b0;
  endtask

  task automatic pulse_start(input int cx, input int cy, input int d, input logic [2:0] col);
    @(negedge clk);
    centre_x = cx[7:0];
    centre_y = cy[6:0];
    diameter = d[7:0];
    colour   = col;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_shape(input int cx, input int cy, input int d,
                           input logic [2:0] col, input bit perturb);
    int r0;
    bit ok;
    clear_fb();
    push_shape(cx, cy, d, col);
    r0 = rises;
    pulse_start(cx, cy, d, col);
    check("done_fall", done, 0);
    if (perturb) begin
      repeat (50) @(negedge clk);
      colour   = ~col;
      diameter = 8'd5;
      centre_x = 8'd3;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_timeout", ok, 1);
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_hold", done, 1);
    check("done_rises", rises - r0, 1);
  endtask

  initial begin
    int bad_y;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_plot", vga_plot, 0);
    check("rst_done", done, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reference shape; vertices and vertical extent from the observed frame.
    run_shape(80, 60, 80, 3'b010, 1'b0);
    check("vertex_120_83", fb[120][83], 1);
    check("vertex_40_83", fb[40][83], 1);
    check("vertex_80_14", fb[80][14], 1);
    bad_y = 0;
    for (int i = 0; i < 160; i++)
      for (int j = 0; j < 120; j++)
        if (fb[i][j] && (j < 14 || j > 94)) bad_y++;
    check("y_extent", bad_y, 0);

    // Same shape with a start pulse landing in ARC1.
    run_shape(80, 60, 80, 3'b010, 1'b1);

    // Back-to-back request straight from DONE.
    run_shape(30, 30, 20, 3'b110, 1'b0);

    // Clipped at the top-left corner.
    run_shape(5, 5, 60, 3'b001, 1'b0);

    // Degenerate radius.
    run_shape(10, 10, 0, 3'b101, 1'b0);

    // Reset in the middle of ARC2, then a full redraw.
    push_shape(80, 60, 80, 3'b111);
    pulse_start(80, 60, 80, 3'b111);
    repeat (700) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_plot", vga_plot, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("midrst_idle_plot", vga_plot, 0);
    run_shape(80, 60, 80, 3'b011, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
